// File: rtl/epl_fi_multi_ctrl.sv
// ============================================================================
//  Module   : epl_fi_multi_ctrl
//  Brief    : Runtime-programmable multi-channel fault injector for the ECC
//             FFRAM data path; optional random bit select via FI_RAND_BIT_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module epl_fi_multi_ctrl #(
    parameter int ADDR_W = 4,
    parameter int CW_W   = 7,
    parameter int NCH    = 2,
    parameter int CNT_W  = 8,
    parameter int RQ_D   = 2
) (
    input  logic              pCLOCK_i,
    input  logic              nRESET_i,
    input  logic              pCfgWe_i,
    input  logic [2:0]        pCfgCh_i,
    input  logic [1:0]        pCfgMode_i,
    input  logic [1:0]        pCfgRpt_i,
    input  logic [ADDR_W-1:0] pCfgAddr_i,
    input  logic [ADDR_W-1:0] pCfgAmask_i,
    input  logic [CW_W-1:0]   pCfgBits_i,
    input  logic [CNT_W-1:0]  pCfgTrig_i,
    input  logic [ADDR_W-1:0] pA_i,
    input  logic              pWRITE_i,
    input  logic              pREAD_i,
    input  logic              pRDVLD_i,
    input  logic [CW_W-1:0]   pWCW_i,
    output logic [CW_W-1:0]   pWCW_o,
    input  logic [CW_W-1:0]   pRCW_i,
    output logic [CW_W-1:0]   pRCW_o,
    output logic              pFiHit_o,
    output logic [CNT_W-1:0]  pFiCnt_o,
    output logic [NCH-1:0]    pChDone_o,
    output logic              pOvf_o
);
    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_ARMED   = 2'd1;
    localparam logic [1:0] c_ST_FIRE    = 2'd2;
    localparam logic [1:0] c_ST_DONE    = 2'd3;
    localparam logic [1:0] c_MODE_OFF   = 2'd0;
    localparam logic [1:0] c_MODE_SA0   = 2'd1;
    localparam logic [1:0] c_MODE_SA1   = 2'd2;
    localparam logic [1:0] c_MODE_FLIP  = 2'd3;
    localparam logic [1:0] c_RPT_PERS   = 2'd1;
    localparam logic [1:0] c_RPT_PERIOD = 2'd2;
    localparam int         c_PW         = (RQ_D > 1) ? $clog2(RQ_D) : 1;
    localparam int         c_QW         = $clog2(RQ_D + 1);

    logic [CW_W-1:0] w_sa0_m  [NCH];
    logic [CW_W-1:0] w_sa1_m  [NCH];
    logic [CW_W-1:0] w_flip_m [NCH];
    logic [CW_W-1:0] w_z, w_o, w_flip;

`ifdef FI_RAND_BIT_EN
    logic [7:0]      r_lfsr;
    logic [7:0]      w_rbit;
    logic [CW_W-1:0] w_rand_mask;

    always_ff @(posedge pCLOCK_i or negedge nRESET_i) begin
        if (!nRESET_i) r_lfsr <= 8'hA5;
        else           r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
    end

    assign w_rbit      = r_lfsr % 8'(CW_W);
    assign w_rand_mask = CW_W'(1) << w_rbit;
`endif

    for (genvar ch = 0; ch < NCH; ch++) begin : g_ch
        logic [1:0]        r_state, w_state_nxt, r_mode, r_rpt;
        logic [ADDR_W-1:0] r_addr, r_amask;
        logic [CW_W-1:0]   r_bits, w_mask;
        logic [CNT_W-1:0]  r_trig, r_cnt, w_cnt_nxt;
        logic              w_cfg, w_match, w_acc, w_fire;

        assign w_cfg   = pCfgWe_i && (pCfgCh_i == 3'(ch));
        assign w_match = ((pA_i ^ r_addr) & ~r_amask) == '0;
        // A same-cycle config write to this channel swallows the access.
        assign w_acc   = !w_cfg && w_match
                       && ((r_state == c_ST_ARMED) || (r_state == c_ST_FIRE))
                       && ((((r_mode == c_MODE_SA0) || (r_mode == c_MODE_SA1)) && pWRITE_i)
                           || ((r_mode == c_MODE_FLIP) && pREAD_i));
        assign w_fire  = w_acc && ((r_state == c_ST_FIRE) || (r_cnt == r_trig));

        always_comb begin
            w_state_nxt = r_state;
            w_cnt_nxt   = r_cnt;
            if (w_cfg) begin
                w_state_nxt = (pCfgMode_i == c_MODE_OFF) ? c_ST_IDLE : c_ST_ARMED;
                w_cnt_nxt   = '0;
            end else if (w_acc && (r_state == c_ST_ARMED)) begin
                if (r_cnt == r_trig) begin
                    case (r_rpt)
                        c_RPT_PERS:   w_state_nxt = c_ST_FIRE;
                        c_RPT_PERIOD: w_cnt_nxt   = '0;
                        default:      w_state_nxt = c_ST_DONE;
                    endcase
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
        end

        always_ff @(posedge pCLOCK_i or negedge nRESET_i) begin
            if (!nRESET_i) begin
                r_state <= c_ST_IDLE;
                r_cnt   <= '0;
                r_mode  <= '0;
                r_rpt   <= '0;
                r_addr  <= '0;
                r_amask <= '0;
                r_bits  <= '0;
                r_trig  <= '0;
            end else begin
                r_state <= w_state_nxt;
                r_cnt   <= w_cnt_nxt;
                if (w_cfg) begin
                    r_mode  <= pCfgMode_i;
                    r_rpt   <= pCfgRpt_i;
                    r_addr  <= pCfgAddr_i;
                    r_amask <= pCfgAmask_i;
                    r_bits  <= pCfgBits_i;
                    r_trig  <= pCfgTrig_i;
                end
            end
        end

`ifdef FI_RAND_BIT_EN
        assign w_mask = (r_bits == '0) ? w_rand_mask : r_bits;
`else
        assign w_mask = r_bits;
`endif

        assign w_sa0_m[ch]   = (w_fire && (r_mode == c_MODE_SA0))  ? w_mask : '0;
        assign w_sa1_m[ch]   = (w_fire && (r_mode == c_MODE_SA1))  ? w_mask : '0;
        assign w_flip_m[ch]  = (w_fire && (r_mode == c_MODE_FLIP)) ? w_mask : '0;
        assign pChDone_o[ch] = (r_state == c_ST_DONE);
    end

    always_comb begin
        w_z    = '0;
        w_o    = '0;
        w_flip = '0;
        for (int i = 0; i < NCH; i++) begin
            w_z    = w_z    | w_sa0_m[i];
            w_o    = w_o    | w_sa1_m[i];
            w_flip = w_flip | w_flip_m[i];
        end
    end

    assign pWCW_o = (pWCW_i & ~w_z) | w_o;

    // Read-alignment queue: flip masks captured at command time, applied on return.
    logic [CW_W-1:0] r_q [RQ_D];
    logic [c_PW-1:0] r_rd_ptr, r_wr_ptr;
    logic [c_QW-1:0] r_qcnt;
    logic            w_empty, w_full, w_pop, w_push;
    logic [CW_W-1:0] w_head;

    assign w_empty = (r_qcnt == '0);
    assign w_full  = (r_qcnt == c_QW'(RQ_D));
    assign w_pop   = pRDVLD_i && !w_empty;
    assign w_push  = pREAD_i && (!w_full || w_pop);
    assign w_head  = r_q[r_rd_ptr];
    assign pRCW_o  = w_pop ? (pRCW_i ^ w_head) : pRCW_i;

    always_ff @(posedge pCLOCK_i or negedge nRESET_i) begin
        if (!nRESET_i) begin
            for (int i = 0; i < RQ_D; i++) r_q[i] <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_qcnt   <= '0;
            pOvf_o   <= 1'b0;
        end else begin
            if (w_push) begin
                r_q[r_wr_ptr] <= w_flip;
                r_wr_ptr      <= (r_wr_ptr == c_PW'(RQ_D - 1)) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) r_rd_ptr <= (r_rd_ptr == c_PW'(RQ_D - 1)) ? '0 : r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_qcnt <= r_qcnt + 1'b1;
                2'b01:   r_qcnt <= r_qcnt - 1'b1;
                default: ;
            endcase
            if (pREAD_i && w_full && !w_pop) pOvf_o <= 1'b1;
        end
    end

    logic           w_wr_inj, w_rd_inj;
    logic [1:0]     w_inc;
    logic [CNT_W:0] w_sum;
    logic [CNT_W-1:0] r_ficnt;

    assign w_wr_inj = |(w_z | w_o);
    assign w_rd_inj = w_pop && (|w_head);
    assign pFiHit_o = w_wr_inj || w_rd_inj;
    assign w_inc    = {1'b0, w_wr_inj} + {1'b0, w_rd_inj};
    assign w_sum    = {1'b0, r_ficnt} + {{(CNT_W-1){1'b0}}, w_inc};

    always_ff @(posedge pCLOCK_i or negedge nRESET_i) begin
        if (!nRESET_i) r_ficnt <= '0;
        else           r_ficnt <= w_sum[CNT_W] ? '1 : w_sum[CNT_W-1:0];
    end

    assign pFiCnt_o = r_ficnt;

endmodule

`default_nettype wire

// File: tb/tb_epl_fi_multi_ctrl.sv
// ============================================================================
//  Module   : tb_epl_fi_multi_ctrl
//  Brief    : Scoreboard bench for epl_fi_multi_ctrl (default parameters).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_epl_fi_multi_ctrl;
    logic       clk;
    logic       nRESET_i;
    logic       pCfgWe_i;
    logic [2:0] pCfgCh_i;
    logic [1:0] pCfgMode_i, pCfgRpt_i;
    logic [3:0] pCfgAddr_i, pCfgAmask_i, pA_i;
    logic [6:0] pCfgBits_i, pWCW_i, pWCW_o, pRCW_i, pRCW_o;
    logic [7:0] pCfgTrig_i, pFiCnt_o;
    logic       pWRITE_i, pREAD_i, pRDVLD_i, pFiHit_o, pOvf_o;
    logic [1:0] pChDone_o;

    int n_checks = 0;
    int n_errors = 0;

    // Write entries are {expected hit, expected codeword}; read entries are flip masks.
    logic [7:0] wq[$];
    logic [6:0] rq[$];

    epl_fi_multi_ctrl u_dut (
        .pCLOCK_i   (clk),
        .nRESET_i   (nRESET_i),
        .pCfgWe_i   (pCfgWe_i),
        .pCfgCh_i   (pCfgCh_i),
        .pCfgMode_i (pCfgMode_i),
        .pCfgRpt_i  (pCfgRpt_i),
        .pCfgAddr_i (pCfgAddr_i),
        .pCfgAmask_i(pCfgAmask_i),
        .pCfgBits_i (pCfgBits_i),
        .pCfgTrig_i (pCfgTrig_i),
        .pA_i       (pA_i),
        .pWRITE_i   (pWRITE_i),
        .pREAD_i    (pREAD_i),
        .pRDVLD_i   (pRDVLD_i),
        .pWCW_i     (pWCW_i),
        .pWCW_o     (pWCW_o),
        .pRCW_i     (pRCW_i),
        .pRCW_o     (pRCW_o),
        .pFiHit_o   (pFiHit_o),
        .pFiCnt_o   (pFiCnt_o),
        .pChDone_o  (pChDone_o),
        .pOvf_o     (pOvf_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_cfg(input logic [2:0] ch, input logic [1:0] mode, input logic [1:0] rpt,
                           input logic [3:0] addr, input logic [3:0] amask,
                           input logic [6:0] bits, input logic [7:0] trig);
        pCfgWe_i    = 1'b1;
        pCfgCh_i    = ch;
        pCfgMode_i  = mode;
        pCfgRpt_i   = rpt;
        pCfgAddr_i  = addr;
        pCfgAmask_i = amask;
        pCfgBits_i  = bits;
        pCfgTrig_i  = trig;
    endtask

    task automatic wr(input logic [3:0] a, input logic [6:0] cw, input logic [6:0] exp_cw, input logic hit);
        pA_i     = a;
        pWRITE_i = 1'b1;
        pWCW_i   = cw;
        wq.push_back({hit, exp_cw});
    endtask

    task automatic rd(input logic [3:0] a, input logic [6:0] mask, input logic tracked);
        pA_i    = a;
        pREAD_i = 1'b1;
        if (tracked) rq.push_back(mask);
    endtask

    task automatic rv(input logic [6:0] data);
        pRDVLD_i = 1'b1;
        pRCW_i   = data;
    endtask

    // Inputs are driven at the falling edge; combinational outputs are checked
    // shortly after, then the rising edge is taken and strobes are dropped.
    task automatic tick();
        logic [7:0] went;
        logic [6:0] m;
        logic       eh;
        eh = 1'b0;
        #2;
        if (pWRITE_i) begin
            went = (wq.size() > 0) ? wq.pop_front() : {1'b0, pWCW_i};
            chk("wcw", pWCW_o, went[6:0]);
            eh = eh | went[7];
        end
        if (pRDVLD_i) begin
            m = (rq.size() > 0) ? rq.pop_front() : 7'h00;
            chk("rcw", pRCW_o, pRCW_i ^ m);
            eh = eh | (m != 7'h00);
        end
        chk("hit", pFiHit_o, eh);
        @(negedge clk);
        pCfgWe_i = 1'b0;
        pWRITE_i = 1'b0;
        pREAD_i  = 1'b0;
        pRDVLD_i = 1'b0;
    endtask

    initial begin
        nRESET_i = 1'b0;
        set_cfg(3'd0, 2'b00, 2'b00, 4'h0, 4'h0, 7'h00, 8'h00);
        pCfgWe_i = 1'b0;
        pA_i = 4'h0; pWRITE_i = 1'b0; pREAD_i = 1'b0; pRDVLD_i = 1'b0;
        pWCW_i = 7'h55; pRCW_i = 7'h2A;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_hit",  pFiHit_o, 1'b0);
        chk("rst_cnt",  pFiCnt_o, 8'h00);
        chk("rst_done", pChDone_o, 2'b00);
        chk("rst_ovf",  pOvf_o, 1'b0);
        chk("rst_wcw",  pWCW_o, 7'h55);
        chk("rst_rcw",  pRCW_o, 7'h2A);
        nRESET_i = 1'b1;
        @(negedge clk);

        // One-shot stuck-at-0 on bit 0, fires on the third matching write.
        set_cfg(3'd0, 2'b01, 2'b00, 4'h5, 4'h0, 7'h01, 8'd2); tick();
        wr(4'h5, 7'h7F, 7'h7F, 1'b0); tick();
        wr(4'h4, 7'h7F, 7'h7F, 1'b0); tick();
        wr(4'h5, 7'h7F, 7'h7F, 1'b0); tick();
        wr(4'h5, 7'h7F, 7'h7E, 1'b1); tick();
        chk("t1_done", pChDone_o, 2'b01);
        chk("t1_cnt",  pFiCnt_o, 8'd1);
        wr(4'h5, 7'h7F, 7'h7F, 1'b0); tick();
        chk("t1_cnt2", pFiCnt_o, 8'd1);

        // Overlapping stuck-at-0 / stuck-at-1; stuck-at-1 dominates.
        set_cfg(3'd0, 2'b01, 2'b01, 4'h0, 4'hF, 7'h0C, 8'd0); tick();
        chk("t2_done_clr", pChDone_o, 2'b00);
        set_cfg(3'd1, 2'b10, 2'b01, 4'h0, 4'hF, 7'h04, 8'd0); tick();
        wr(4'h9, 7'h00, 7'h04, 1'b1); tick();
        chk("t2_cnt", pFiCnt_o, 8'd2);
        wr(4'h2, 7'h7F, 7'h77, 1'b1); tick();
        chk("t2_cnt2", pFiCnt_o, 8'd3);
        set_cfg(3'd0, 2'b00, 2'b00, 4'h0, 4'h0, 7'h00, 8'd0); tick();
        set_cfg(3'd1, 2'b00, 2'b00, 4'h0, 4'h0, 7'h00, 8'd0); tick();
        wr(4'h9, 7'h7F, 7'h7F, 1'b0); tick();

        // Periodic read flip, T=1: every second matching read flips bit 4.
        set_cfg(3'd1, 2'b11, 2'b10, 4'h3, 4'h0, 7'h10, 8'd1); tick();
        rd(4'h3, 7'h00, 1'b1); tick();
        rd(4'h3, 7'h10, 1'b1); tick();
        rd(4'h3, 7'h00, 1'b1); rv(7'h21); tick();
        rd(4'h3, 7'h10, 1'b1); rv(7'h22); tick();
        rv(7'h23); tick();
        rv(7'h24); tick();
        chk("t3_cnt", pFiCnt_o, 8'd5);
        chk("t3_ovf", pOvf_o, 1'b0);

        // Overflow: third read dropped, its channel count still advances.
        rd(4'h3, 7'h00, 1'b1); tick();
        rd(4'h3, 7'h10, 1'b1); tick();
        chk("t4_ovf_pre", pOvf_o, 1'b0);
        rd(4'h3, 7'h00, 1'b0); tick();
        chk("t4_ovf", pOvf_o, 1'b1);
        rv(7'h0F); tick();
        rv(7'h0F); tick();
        chk("t4_cnt", pFiCnt_o, 8'd6);
        rv(7'h33); tick();
        rd(4'h3, 7'h10, 1'b1); tick();
        rv(7'h40); tick();
        chk("t4_cnt2", pFiCnt_o, 8'd7);

        // Config collides with a matching write: neither counted nor fired.
        set_cfg(3'd0, 2'b01, 2'b00, 4'h5, 4'h0, 7'h01, 8'd1);
        wr(4'h5, 7'h7F, 7'h7F, 1'b0); tick();
        wr(4'h5, 7'h7F, 7'h7F, 1'b0); tick();
        wr(4'h5, 7'h7F, 7'h7E, 1'b1); tick();
        chk("t5_done", pChDone_o, 2'b01);
        chk("t5_cnt",  pFiCnt_o, 8'd8);
        set_cfg(3'd2, 2'b01, 2'b01, 4'h0, 4'hF, 7'h7F, 8'd0); tick();
        wr(4'h0, 7'h7F, 7'h7F, 1'b0); tick();
        chk("t5_done2", pChDone_o, 2'b01);
        chk("t5_ovf",   pOvf_o, 1'b1);

        // Reset with two flips queued discards them.
        set_cfg(3'd1, 2'b11, 2'b01, 4'h0, 4'hF, 7'h7F, 8'd0); tick();
        rd(4'h1, 7'h7F, 1'b1); tick();
        rd(4'h2, 7'h7F, 1'b1); tick();
        chk("t6_cnt_pre", pFiCnt_o, 8'd8);
        nRESET_i = 1'b0;
        #2;
        chk("t6_cnt",  pFiCnt_o, 8'd0);
        chk("t6_done", pChDone_o, 2'b00);
        chk("t6_ovf",  pOvf_o, 1'b0);
        rq.delete();
        @(negedge clk);
        nRESET_i = 1'b1;
        @(negedge clk);
        rv(7'h2A); tick();
        rd(4'h1, 7'h00, 1'b1); tick();
        rv(7'h15); tick();
        chk("t6_cnt2", pFiCnt_o, 8'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/epl_fi_multi_ctrl.md
Name: epl_fi_multi_ctrl

Overview:
- Parametrised, runtime-programmable fault-injection controller for the ECC-protected FFRAM data path.
- Next generation of the fixed write-failure and read-disturb FI pair, which were configured only by compile-time masks.
- Write port sits between the ECC encoder and column access. Read port sits between the read mux and the ECC decoder.
- Provides NCH independent channels. Each channel has its own address match, bit mask, fault mode, trigger count and repeat mode.
- Read faults are aligned to returning data through a small command queue.

Parameters:
ADDR_W, 4, word address width
CW_W, 7, codeword width (data plus parity)
NCH, 2, number of FI channels (1..8)
CNT_W, 8, trigger counter and injection counter width
RQ_D, 2, read-alignment queue depth (outstanding reads, 1..4)

Ports:
pCLOCK_i  in  1  clock, rising edge
nRESET_i  in  1  asynchronous active-low reset
pCfgWe_i  in  1  configuration write strobe
pCfgCh_i  in  3  target channel; writes to channel index >= NCH are ignored
pCfgMode_i  in  2  00 off, 01 write stuck-at-0, 10 write stuck-at-1, 11 read bit-flip
pCfgRpt_i  in  2  00 one-shot, 01 persistent, 10 periodic, 11 treated as 00
pCfgAddr_i  in  ADDR_W  match address
pCfgAmask_i  in  ADDR_W  address don't-care mask (1 = ignore this bit)
pCfgBits_i  in  CW_W  codeword bit mask
pCfgTrig_i  in  CNT_W  trigger value T
pA_i  in  ADDR_W  access address
pWRITE_i  in  1  write command (encoder strobe)
pREAD_i  in  1  read command
pRDVLD_i  in  1  read codeword valid at decoder input
pWCW_i / pWCW_o  in / out  CW_W  write codeword before / after injection
pRCW_i / pRCW_o  in / out  CW_W  read codeword before / after injection
pFiHit_o  out  1  injection applied this cycle
pFiCnt_o  out  CNT_W  total injections, saturating
pChDone_o  out  NCH  channel finished (one-shot only)
pOvf_o  out  1  sticky: read dropped because queue was full

Behaviour:
Reset values:
- All channels IDLE with every field zero; queue empty.
- pFiHit_o=0, pFiCnt_o=0, pChDone_o=0, pOvf_o=0.
- pWCW_o=pWCW_i and pRCW_o=pRCW_i (pure pass-through).

Address match:
- A channel matches when ((pA_i ^ addr) & ~amask) == 0.
- Write-mode channels count only matching pWRITE_i. Read-mode channels count only matching pREAD_i.

Channel FSM:
- IDLE -> ARMED on a config write with mode != 00. Config write with mode 00 -> IDLE.
- ARMED: per-channel counter c starts at 0 and increments on each match.
- A match with c==T fires:
  - one-shot -> DONE and pChDone_o[ch]=1.
  - persistent -> FIRE; every later match also fires.
  - periodic -> c resets to 0 and the channel stays ARMED, so it fires every (T+1)-th match.
- DONE holds until the next config write.
- A config write on any state reloads all fields, clears c, and clears pChDone_o[ch].
- Config write in the same cycle as a matching access for that channel: config wins and the access is neither counted nor fired.

Write path (zero latency, combinational):
- z = OR of bit masks of firing stuck-at-0 channels; o = OR of bit masks of firing stuck-at-1 channels.
- pWCW_o = (pWCW_i & ~z) | o, so stuck-at-1 dominates.

Read path:
- On pREAD_i, push {flip mask = OR of bit masks of firing read channels} into the FIFO. Counters update at command time.
- On pRDVLD_i, pop the head and drive pRCW_o = pRCW_i ^ head mask.
- pRDVLD_i with queue empty: pass-through, no pop.
- pREAD_i with queue full and no simultaneous pop: read not tracked, pOvf_o set. Channel counters still advance.
- Push and pop in the same cycle are both legal at any occupancy, including full.

pFiHit_o and pFiCnt_o:
- pFiHit_o=1 in a cycle with a nonzero applied mask: a write with z|o != 0, or a popped nonzero flip mask.
- A write injection and a read injection in the same cycle both count, +2 on pFiCnt_o.
- pFiCnt_o saturates at all-ones.

Reset asserted mid-operation: all state clears immediately; pending queued flips are discarded.

Optional Feature:
Macro FI_RAND_BIT_EN.
- Defined:
  - An 8-bit LFSR (x^8+x^6+x^5+x^4+1, seed 8'hA5) advances every clock.
  - A firing channel whose bit mask is all zero uses a one-hot mask at bit (lfsr % CW_W), sampled in the fire cycle.
- Not defined:
  - A zero bit mask injects nothing and is not counted.
  - The channel FSM still advances.

Test Plan:
- ch0 mode 01, one-shot, addr 4'h5, amask 0, bits 7'h01, T=2; three writes to 5 with pWCW_i=7'h7F -> third pWCW_o=7'h7E, pChDone_o[0]=1, pFiCnt_o=1; first two and a fourth write unchanged.
- ch0 write stuck-at-0 bits 7'h0C and ch1 write stuck-at-1 bits 7'h04, both persistent T=0, amask 4'hF; write 7'h00 -> pWCW_o=7'h04.
- ch1 mode 11, periodic, T=1, addr 4'h3; reads to 3 at cycles 0,1,2,3, data returning two cycles later -> flips on the 2nd and 4th returned words only.
- RQ_D=2; three pREAD_i back-to-back with no pRDVLD_i -> pOvf_o=1; the two queued masks apply in order.
- Config write to ch0 in the same cycle as a matching write -> no injection, c stays 0.
- Reset pulsed with 2 reads queued -> queue empty, pFiCnt_o=0, next pRDVLD_i passes pRCW_i unchanged.
